// File: rtl/e203_subsys_dma_icb.sv
// Single-channel word DMA with an ICB configuration slave and an ICB master port.
// Optional feature: define E203_DMA_ERR_ABORT_EN to abort a transfer on a master response error.
module e203_subsys_dma_icb #(
    parameter int LEN_W = 16,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_icb_cmd_valid,
    output logic             s_icb_cmd_ready,
    input  logic [4:0]       s_icb_cmd_addr,
    input  logic             s_icb_cmd_read,
    input  logic [31:0]      s_icb_cmd_wdata,
    input  logic [3:0]       s_icb_cmd_wmask,
    output logic             s_icb_rsp_valid,
    input  logic             s_icb_rsp_ready,
    output logic             s_icb_rsp_err,
    output logic [31:0]      s_icb_rsp_rdata,
    output logic             m_icb_cmd_valid,
    input  logic             m_icb_cmd_ready,
    output logic [AW-1:0]    m_icb_cmd_addr,
    output logic             m_icb_cmd_read,
    output logic [31:0]      m_icb_cmd_wdata,
    output logic [3:0]       m_icb_cmd_wmask,
    input  logic             m_icb_rsp_valid,
    output logic             m_icb_rsp_ready,
    input  logic             m_icb_rsp_err,
    input  logic [31:0]      m_icb_rsp_rdata,
    output logic             dma_irq
);

    // state     | meaning
    // ST_IDLE   | no transfer, waiting for START
    // ST_RD_CMD | read command presented at cur_src
    // ST_RD_RSP | waiting for read data
    // ST_WR_CMD | write command presented at cur_dst with buffered word
    // ST_WR_RSP | waiting for write response, then advance pointers
    // ST_FIN    | set DONE and return to idle
    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_CMD, ST_RD_RSP, ST_WR_CMD, ST_WR_RSP, ST_FIN
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_src;
    logic [AW-1:0]      r_dst;
    logic [LEN_W-1:0]   r_len;
    logic               r_irq_en;
    logic               r_done;
    logic               r_err;
    logic [AW-1:0]      r_cur_src;
    logic [AW-1:0]      r_cur_dst;
    logic [LEN_W-1:0]   r_cnt;
    logic [31:0]        r_buf;
    logic               r_m_valid;
    logic               r_m_read;
    logic [AW-1:0]      r_m_addr;
    logic               r_s_rsp_valid;
    logic               r_s_rsp_err;
    logic [31:0]        r_s_rsp_rdata;

    logic               w_cmd_hs;
    logic               w_wr_en;
    logic [2:0]         w_sel;
    logic               w_busy;
    logic               w_start;
    logic [31:0]        w_rdata;
    logic               w_rerr;
    logic               w_rsp_abort;
    logic               w_unused;

`ifdef E203_DMA_ERR_ABORT_EN
    assign w_rsp_abort = m_icb_rsp_valid & m_icb_rsp_err;
    assign w_unused    = |s_icb_cmd_addr[1:0];
`else
    assign w_rsp_abort = 1'b0;
    assign w_unused    = |{s_icb_cmd_addr[1:0], m_icb_rsp_err};
`endif

    assign s_icb_cmd_ready = ~r_s_rsp_valid | s_icb_rsp_ready;
    assign w_cmd_hs        = s_icb_cmd_valid & s_icb_cmd_ready;
    assign w_wr_en         = w_cmd_hs & ~s_icb_cmd_read & (s_icb_cmd_wmask == 4'hF);
    assign w_sel           = s_icb_cmd_addr[4:2];
    assign w_busy          = (r_state != ST_IDLE);
    assign w_start         = w_wr_en & (w_sel == 3'd3) & s_icb_cmd_wdata[0] & ~w_busy;

    always_comb begin
        w_rdata = 32'h0;
        w_rerr  = 1'b0;
        case (w_sel)
            3'd0:    w_rdata = 32'(r_src);
            3'd1:    w_rdata = 32'(r_dst);
            3'd2:    w_rdata = 32'(r_len);
            3'd3:    w_rdata = {30'b0, r_irq_en, 1'b0};
            3'd4:    w_rdata = {29'b0, r_err, r_done, w_busy};
            default: w_rerr  = 1'b1;
        endcase
    end

    // FSM updates sit after the register-write decode so a DONE/ERR set wins over a same-cycle w1c
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_cur_src     <= '0;
            r_cur_dst     <= '0;
            r_cnt         <= '0;
            r_buf         <= 32'h0;
            r_m_valid     <= 1'b0;
            r_m_read      <= 1'b0;
            r_m_addr      <= '0;
            r_s_rsp_valid <= 1'b0;
            r_s_rsp_err   <= 1'b0;
            r_s_rsp_rdata <= 32'h0;
        end else begin
            if (w_cmd_hs) begin
                r_s_rsp_valid <= 1'b1;
                r_s_rsp_rdata <= s_icb_cmd_read ? w_rdata : 32'h0;
                r_s_rsp_err   <= w_rerr;
            end else if (s_icb_rsp_ready) begin
                r_s_rsp_valid <= 1'b0;
            end

            if (w_wr_en) begin
                case (w_sel)
                    3'd0: if (!w_busy) r_src <= AW'(s_icb_cmd_wdata);
                    3'd1: if (!w_busy) r_dst <= AW'(s_icb_cmd_wdata);
                    3'd2: if (!w_busy) r_len <= s_icb_cmd_wdata[LEN_W-1:0];
                    3'd3: begin
                        r_irq_en <= s_icb_cmd_wdata[1];
                        if (w_start) begin
                            r_err  <= 1'b0;
                            r_done <= (r_len == '0);
                        end
                    end
                    3'd4: begin
                        if (s_icb_cmd_wdata[1]) r_done <= 1'b0;
                        if (s_icb_cmd_wdata[2]) r_err  <= 1'b0;
                    end
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start && (r_len != '0)) begin
                        r_cur_src <= r_src;
                        r_cur_dst <= r_dst;
                        r_cnt     <= r_len;
                        r_m_valid <= 1'b1;
                        r_m_read  <= 1'b1;
                        r_m_addr  <= r_src;
                        r_state   <= ST_RD_CMD;
                    end
                end
                ST_RD_CMD: begin
                    if (m_icb_cmd_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_RD_RSP;
                    end
                end
                ST_RD_RSP: begin
                    if (m_icb_rsp_valid) begin
                        if (w_rsp_abort) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_buf     <= m_icb_rsp_rdata;
                            r_m_valid <= 1'b1;
                            r_m_read  <= 1'b0;
                            r_m_addr  <= r_cur_dst;
                            r_state   <= ST_WR_CMD;
                        end
                    end
                end
                ST_WR_CMD: begin
                    if (m_icb_cmd_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_WR_RSP;
                    end
                end
                ST_WR_RSP: begin
                    if (m_icb_rsp_valid) begin
                        if (w_rsp_abort) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cur_src <= r_cur_src + AW'(4);
                            r_cur_dst <= r_cur_dst + AW'(4);
                            r_cnt     <= r_cnt - LEN_W'(1);
                            if (r_cnt == LEN_W'(1)) begin
                                r_state <= ST_FIN;
                            end else begin
                                r_m_valid <= 1'b1;
                                r_m_read  <= 1'b1;
                                r_m_addr  <= r_cur_src + AW'(4);
                                r_state   <= ST_RD_CMD;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_icb_rsp_valid = r_s_rsp_valid;
    assign s_icb_rsp_err   = r_s_rsp_err;
    assign s_icb_rsp_rdata = r_s_rsp_rdata;
    assign m_icb_cmd_valid = r_m_valid;
    assign m_icb_cmd_addr  = r_m_addr;
    assign m_icb_cmd_read  = r_m_read;
    assign m_icb_cmd_wdata = r_buf;
    assign m_icb_cmd_wmask = 4'hF;
    assign m_icb_rsp_ready = 1'b1;
    assign dma_irq         = r_done & r_irq_en;

endmodule
